// File: rtl/mod_addsub_pipe_pkg.sv
// Shared op encoding and helpers for the modular add/sub pipeline.
// Package mod_arith_pkg: op_e (OP_ADD/OP_SUB), clog2().
package mod_arith_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// Operand/result stream bundle for mod_addsub_pipe.
// in_* : operand beat (valid/ready), out_* : result beat (valid/ready).
interface mod_addsub_pipe_if
  import mod_arith_pkg::*;
#(
  parameter int W     = 5,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  op_e              in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_res, out_tag, out_err
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_res, out_tag, out_err
  );
endinterface

// File: rtl/mod_addsub_pipe_cand.sv
// Candidate generation: c0/c1 for modular add/sub, W+2-bit signed.
// Ports: i_a, i_b (W), i_op (op_e) -> o_c0, o_c1 (signed W+2).
module mod_addsub_cand
  import mod_arith_pkg::*;
#(
  parameter int MODULUS = 17,
  parameter int W       = 5
) (
  input  logic [W-1:0]        i_a,
  input  logic [W-1:0]        i_b,
  input  op_e                 i_op,
  output logic signed [W+1:0] o_c0,
  output logic signed [W+1:0] o_c1
);
  localparam logic signed [W+1:0] LP_M =
    (W+2)'(MODULUS);

  logic signed [W+1:0] w_a;
  logic signed [W+1:0] w_b;

  assign w_a = signed'({2'b00, i_a});
  assign w_b = signed'({2'b00, i_b});

  always_comb begin
    o_c0 = w_a + w_b;
    o_c1 = w_a + w_b - LP_M;
    if (i_op == OP_SUB) begin
      o_c0 = w_a - w_b + LP_M;
      o_c1 = w_a - w_b;
    end
  end
endmodule

// File: rtl/mod_addsub_pipe.sv
// Pipelined modular adder/subtractor, 3 stages, global stall.
// Ports: clk, rst (async high), bus (mod_addsub_pipe_if.slave).
// Optional MOD_RANGE_CHECK_EN: flags operands >= MODULUS via out_err.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int MODULUS = 17,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  mod_addsub_pipe_if.slave  bus
);
  localparam int W = clog2(MODULUS);

  logic w_adv;
  logic w_acc;
  logic w_rng_err;

  logic             r_v1;
  op_e              r_op1;
  logic [W-1:0]     r_a1;
  logic [W-1:0]     r_b1;
  logic [TAG_W-1:0] r_tag1;
  logic             r_err1;

  logic                r_v2;
  logic signed [W+1:0] r_c0_2;
  logic signed [W+1:0] r_c1_2;
  logic [TAG_W-1:0]    r_tag2;
  logic                r_err2;

  logic             r_v3;
  logic [W-1:0]     r_res3;
  logic [TAG_W-1:0] r_tag3;
  logic             r_err3;

  logic signed [W+1:0] w_c0;
  logic signed [W+1:0] w_c1;
  logic signed [W+1:0] w_sel;
  logic                w_unused;

  // whole pipe moves together; a held output freezes every stage
  assign w_adv = bus.out_ready | ~r_v3;
  assign w_acc = bus.in_valid & w_adv;
  assign bus.in_ready = w_adv;

`ifdef MOD_RANGE_CHECK_EN
  localparam logic [W:0] LP_MR = (W+1)'(MODULUS);
  assign w_rng_err = ({1'b0, bus.in_a} >= LP_MR) |
                     ({1'b0, bus.in_b} >= LP_MR);
`else
  assign w_rng_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_op1  <= OP_ADD;
      r_a1   <= '0;
      r_b1   <= '0;
      r_tag1 <= '0;
      r_err1 <= 1'b0;
    end else if (w_adv) begin
      r_v1   <= w_acc;
      r_op1  <= bus.in_op;
      r_a1   <= bus.in_a;
      r_b1   <= bus.in_b;
      r_tag1 <= bus.in_tag;
      r_err1 <= w_rng_err;
    end
  end

  mod_addsub_cand #(
    .MODULUS (MODULUS),
    .W       (W)
  ) u_cand (
    .i_a  (r_a1),
    .i_b  (r_b1),
    .i_op (r_op1),
    .o_c0 (w_c0),
    .o_c1 (w_c1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_c0_2 <= '0;
      r_c1_2 <= '0;
      r_tag2 <= '0;
      r_err2 <= 1'b0;
    end else if (w_adv) begin
      r_v2   <= r_v1;
      r_c0_2 <= w_c0;
      r_c1_2 <= w_c1;
      r_tag2 <= r_tag1;
      r_err2 <= r_err1;
    end
  end

  // c1 non-negative means the reduced value is c1, else c0
  assign w_sel = r_c1_2[W+1] ? r_c0_2 : r_c1_2;
  assign w_unused = ^w_sel[W+1:W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3   <= 1'b0;
      r_res3 <= '0;
      r_tag3 <= '0;
      r_err3 <= 1'b0;
    end else if (w_adv) begin
      r_v3   <= r_v2;
      r_res3 <= r_err2 ? '0 : w_sel[W-1:0];
      r_tag3 <= r_tag2;
      r_err3 <= r_err2;
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.out_res   = r_res3;
  assign bus.out_tag   = r_tag3;
  assign bus.out_err   = r_err3;
endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Scoreboard bench for mod_addsub_pipe (MODULUS=17, TAG_W=4).
// Directed boundary cases, stall, reset and random traffic.
module tb_mod_addsub_pipe;
  import mod_arith_pkg::*;

  localparam int M     = 17;
  localparam int TAG_W = 4;
  localparam int W     = $clog2(M);

  typedef struct {
    int res;
    int tag;
    int err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   cyc;
  exp_t sb[$];
  int   pop_cyc[$];
  bit   rand_done;

  mod_addsub_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();

  mod_addsub_pipe #(
    .MODULUS (M),
    .TAG_W   (TAG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int got, int exp);
    n_chk = n_chk + 1;
    if (got != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic exp_t model(bit op, int a, int b, int tag);
    exp_t e;
    int   d;
    e.tag = tag;
    e.err = 0;
    e.res = 0;
`ifdef MOD_RANGE_CHECK_EN
    if (a >= M || b >= M) begin
      e.err = 1;
      return e;
    end
`endif
    if (a < M && b < M) begin
      e.res = op ? ((a - b + M) % M) : ((a + b) % M);
    end else begin
      d = op ? (a - b) : (a + b - M);
      e.res = (d >= 0 ? d : d + M) & ((1 << W) - 1);
    end
    return e;
  endfunction

  task automatic send(bit op, int a, int b, int tag);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op ? OP_SUB : OP_ADD;
    bus.in_a     = W'(a);
    bus.in_b     = W'(b);
    bus.in_tag   = TAG_W'(tag);
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (done) sb.push_back(model(op, a, b, tag));
    else chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 500) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drain_left", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // monitor: pop on handshake, check holding while stalled
  initial begin
    bit   held;
    exp_t h;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held && !bus.out_valid) chk("hold_valid", 0, 1);
        if (held && bus.out_valid) begin
          chk("hold_res", int'(bus.out_res), h.res);
          chk("hold_tag", int'(bus.out_tag), h.tag);
        end
        if (bus.out_valid && bus.out_ready) begin
          held = 1'b0;
          if (sb.size() == 0) begin
            chk("extra_output", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("res", int'(bus.out_res), e.res);
            chk("tag", int'(bus.out_tag), e.tag);
            chk("err", int'(bus.out_err), e.err);
            pop_cyc.push_back(cyc);
          end
        end else if (bus.out_valid) begin
          held = 1'b1;
          h.res = int'(bus.out_res);
          h.tag = int'(bus.out_tag);
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n0;
    n_chk = 0;
    n_fail = 0;
    rand_done = 1'b0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_res", int'(bus.out_res), 0);
    chk("rst_out_tag", int'(bus.out_tag), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // latency: accepted beat shows 3 edges later
    send(0, 9, 8, 3);
    @(negedge clk);
    chk("lat_v1", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_v2", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_v3", int'(bus.out_valid), 1);
    chk("lat_res", int'(bus.out_res), 0);
    chk("lat_tag", int'(bus.out_tag), 3);
    drain();

    send(0, 16, 16, 1);
    send(1, 3, 5, 2);
    send(1, 5, 5, 4);
    send(1, 0, 16, 5);
    send(0, 8, 9, 6);
    send(1, 16, 0, 8);
    drain();

    // back-to-back throughput
    k = pop_cyc.size();
    for (int i = 0; i < 8; i++) send(i[0], i + 4, 12 - i, i);
    drain();
    for (int i = 1; i < 8; i++)
      chk("b2b_gap", pop_cyc[k + i] - pop_cyc[k], i);

    // stall with 3 beats in flight
    bus.out_ready = 1'b0;
    send(0, 1, 2, 10);
    send(1, 2, 9, 11);
    send(0, 15, 15, 12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(bus.in_ready), 0);
      chk("stall_valid", int'(bus.out_valid), 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // reset with 2 beats in flight
    bus.out_ready = 1'b0;
    send(0, 4, 4, 13);
    send(0, 5, 5, 14);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst_mid_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    n0 = pop_cyc.size();
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_out", pop_cyc.size() - n0, 0);
    send(1, 7, 2, 9);
    drain();
    chk("rst_one_out", pop_cyc.size() - n0, 1);

    // out-of-range operand
    send(0, 20, 1, 7);
    drain();

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 200; i++)
          send($urandom_range(0, 1), $urandom_range(0, M - 1),
               $urandom_range(0, M - 1), $urandom_range(0, 15));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
